// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, decode-facing queue head, redirect and status.
// master = fetch unit side, slave = memory/decode/environment side.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
);
  logic                                 redirect;
  logic [ADDR_WIDTH-1:0]                redirect_pc;
  logic                                 imem_req_valid;
  logic                                 imem_req_ready;
  logic [ADDR_WIDTH-1:0]                imem_req_address;
  logic                                 imem_resp_valid;
  logic [31:0]                          imem_resp_data;
  logic                                 instr_valid;
  logic                                 instr_ready;
  logic [31:0]                          instr;
  logic [ADDR_WIDTH-1:0]                instr_pc;
  logic [$clog2(QUEUE_DEPTH+1)-1:0]     queue_count;
  logic                                 protocol_error;

  modport master (
    input  redirect, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
    output imem_req_valid, imem_req_address, instr_valid, instr, instr_pc, queue_count,
           protocol_error
  );

  modport slave (
    output redirect, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
    input  imem_req_valid, imem_req_address, instr_valid, instr, instr_pc, queue_count,
           protocol_error
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited sequential requests, in-order responses buffered
// with their PCs in a small FIFO, redirect flushes the queue and drops in-flight responses.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WORD_C = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] expect_pc_q, expect_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic                  perr_q, perr_d;

  logic [31:0]           q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc    [QUEUE_DEPTH];

  logic                  credit_ok, req_valid, req_fire;
  logic                  resp_ok, resp_keep, push, pop;
  logic [ADDR_WIDTH-1:0] redirect_pc_al;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  always_comb begin
    // Outstanding requests plus queued entries never exceed the queue size.
    credit_ok      = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_C;
    req_valid      = !reset && !bus.redirect && credit_ok;
    req_fire       = req_valid && bus.imem_req_ready;
    resp_ok        = bus.imem_resp_valid && (inflight_q != '0);
    resp_keep      = resp_ok && (drop_q == '0);
    push           = resp_keep && !bus.redirect;
    pop            = (count_q != '0) && bus.instr_ready && !bus.redirect;
    redirect_pc_al = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    fetch_pc_d  = fetch_pc_q;
    expect_pc_d = expect_pc_q;
    drop_d      = drop_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    inflight_d  = inflight_q + CW'(req_fire) - CW'(resp_ok);
    perr_d      = perr_q | (bus.imem_resp_valid && (inflight_q == '0));

    if (bus.redirect) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc_d  = redirect_pc_al;
      expect_pc_d = redirect_pc_al;
      drop_d      = inflight_q - CW'(resp_ok);
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
    end else begin
      if (req_fire)             fetch_pc_d = fetch_pc_q + WORD_C;
      if (resp_ok && !resp_keep) drop_d    = drop_q - CW'(1);
      if (push) begin
        expect_pc_d = expect_pc_q + WORD_C;
        wr_ptr_d    = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      expect_pc_q <= RESET_PC;
      inflight_q  <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      perr_q      <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      expect_pc_q <= expect_pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      perr_q      <= perr_d;
    end
  end

  // Queue storage carries data only; validity lives in count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      q_instr[wr_ptr_q] <= bus.imem_resp_data;
      q_pc[wr_ptr_q]    <= expect_pc_q;
    end
  end

  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_req_address = fetch_pc_q;
  assign bus.instr_valid      = (count_q != '0);
  assign bus.instr            = q_instr[rd_ptr_q];
  assign bus.instr_pc         = q_pc[rd_ptr_q];
  assign bus.queue_count      = count_q;
  assign bus.protocol_error   = perr_q;
endmodule
